mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single-ported data memory between three requesters: the block-fetch sequencer (req 0), the load/store unit (req 1) and instruction fetch (req 2). Each grant is a locked burst of 1–8 consecutive words. The arbiter drives the memory address, enable and write lines, and returns read data tagged with a beat index. Downstream logic uses that index directly as the register-file write select. It sits between the requesters and the memory macro and replaces the per-requester address muxing.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data word width
- NREQ, 3, number of requesters (fixed at 3; the priority logic is written for 3)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  3  per-requester burst request, level
- we  input  3  per-requester write (1) / read (0)
- addr  input  3*ADDR_W  start address, requester i at bits [i*ADDR_W +: ADDR_W]
- len  input  9  burst length minus 1, requester i at [i*3 +: 3]
- wdata  input  3*DATA_W  write data for the current beat
- gnt  output  3  one-hot; high for the whole burst owned by requester i
- beat_ack  output  3  high in each cycle a beat of requester i is on the memory bus
- rvalid  output  3  read data valid for requester i
- rbeat  output  3  beat index (0..len) of the data on rdata
- rdata  output  DATA_W  read data; a pass-through of mem_rdata
- busy  output  1  burst in progress
- mem_en, mem_we  output  1  memory enable and write strobe
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  synchronous-read memory output, valid the cycle after a read beat

## Operation
- States: IDLE and BURST.
- **IDLE:** if any req bit is high at a clock edge:
  - Pick a winner by round-robin. The search starts at last_gnt+1 mod 3 and wraps.
  - Latch the winner's addr, len and we.
  - Capture beat 0: mem_addr, and mem_wdata from the winner's wdata slice.
  - Set gnt, mem_en, busy; clear beat counter; go to BURST.
- **BURST:** one beat per cycle.
  - At each edge where beat < len: beat++, mem_addr++, mem_wdata re-sampled from the granted wdata slice.
  - At the edge where beat == len: mem_en, gnt and busy clear, last_gnt updates to the winner, and the state returns to IDLE.
- Address arithmetic is modulo 2^ADDR_W; 0xFFFF+1 wraps to 0x0000.
- beat_ack[g] = mem_en & gnt[g], registered with the bus.
  - Requester wdata for beat 0 must be valid together with req.
  - During each beat_ack cycle the requester presents the next word before the following edge.
- Reads:
  - rvalid[g] and rbeat are the bus-cycle values of (mem_en & ~mem_we & gnt[g]) and beat, delayed one cycle.
  - rdata = mem_rdata.
- addr, len and we are sampled only at grant; changes during a burst are ignored.
- Dropping req mid-burst does not abort: the burst runs to len.
- Requesters that are not granted see gnt, beat_ack and rvalid at 0.

## Timing
- Reset (asynchronous assert):
  - state=IDLE and last_gnt=2, so requester 0 has top priority after reset.
  - gnt, beat_ack, rvalid, rbeat, busy, mem_en, mem_we, mem_addr and mem_wdata are all 0.
  - A read in flight is dropped; no rvalid follows reset.
- Grant latency: req sampled high at edge k puts beat 0 on the bus in cycle k (after edge k).
- Burst occupancy: beats occupy bus cycles k..k+len; mem_en is low in cycle k+len+1.
- Next arbitration is at edge k+len+2 at the earliest, giving exactly one idle bus cycle between bursts.
- Read return: data for beat n appears in cycle k+n+1; the last rvalid is in cycle k+len+1.
- Simultaneous requests: only one winner per arbitration; losers hold req and are served in rotation.
- A requester that re-requests immediately after its own burst is served last among those pending.
- A single-requester stream gets back-to-back bursts separated by one idle cycle.
- len=0 gives a single-beat burst: one bus cycle, and gnt high for one cycle.

## Test plan
- **Block fetch read:** after reset, req0 with addr=0x0040, len=7, we=0.
  - Bus addresses are 0x0040..0x0047 in 8 consecutive cycles.
  - rvalid[0] is high for 8 cycles with rbeat 0..7, one cycle after each beat.
  - gnt[1] and gnt[2] stay 0 throughout.
- **Round-robin:** req=3'b111 held, every len=0.
  - Grant order is 0,1,2,0,1,2, with one idle cycle between grants.
  - gnt is never multi-hot.
- **Write burst:** req1 with addr=0x1000, len=3, we=1, and wdata advancing 0xA000..0xA003 on beat_ack.
  - The memory sees those four writes at 0x1000..0x1003.
  - rvalid stays 0.
- **Address wrap:** req2 with addr=0xFFFE, len=3.
  - mem_addr sequence is 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **req drop and field change mid-burst:** req0 len=5; at beat 2 deassert req0 and change addr/len.
  - All 6 beats are issued at the original addresses.
- **Reset mid-burst:** assert rst_n=0 during beat 3 of a len=7 read.
  - All outputs go to 0 immediately and no further rvalid appears.
  - After release, with req1 and req0 both pending, req0 wins.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory bundle for the data-memory port arbiter.
// slave = arbiter side; master = requesters plus memory macro.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int NREQ   = 3
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*3-1:0]      len;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        beat_ack;
  logic [NREQ-1:0]        rvalid;
  logic [2:0]             rbeat;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;
  logic                   mem_en;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  req, we, addr, len, wdata, mem_rdata,
    output gnt, beat_ack, rvalid, rbeat, rdata, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, len, wdata, mem_rdata,
    input  gnt, beat_ack, rvalid, rbeat, rdata, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting locked 1-8 word bursts on a single-ported memory;
// read data returns one cycle after each read beat, tagged with its beat index.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int NREQ   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BURST} state_e;

  state_e state_q, state_d;

  logic [NREQ-1:0][ADDR_W-1:0] addr_v;
  logic [NREQ-1:0][2:0]        len_v;
  logic [NREQ-1:0][DATA_W-1:0] wdata_v;

  logic [1:0]        last_gnt_q, last_gnt_d;
  logic [1:0]        gidx_q, gidx_d;
  logic [1:0]        win;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        beat_q, beat_d;
  logic [2:0]        rbeat_q, rbeat_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              in_burst;
  logic              last_beat;

  assign addr_v    = bus.addr;
  assign len_v     = bus.len;
  assign wdata_v   = bus.wdata;
  assign in_burst  = (state_q == BURST);
  assign last_beat = (beat_q == len_q);

  // Rotating priority: search begins just after the last requester served.
  always_comb begin
    win = 2'd0;
    case (last_gnt_q)
      2'd0:    if (bus.req[1]) win = 2'd1; else if (bus.req[2]) win = 2'd2; else win = 2'd0;
      2'd1:    if (bus.req[2]) win = 2'd2; else if (bus.req[0]) win = 2'd0; else win = 2'd1;
      default: if (bus.req[0]) win = 2'd0; else if (bus.req[1]) win = 2'd1; else win = 2'd2;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.req) state_d = BURST;
      BURST:   if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_gnt_d  = last_gnt_q;
    gidx_d      = gidx_q;
    gnt_d       = gnt_q;
    len_d       = len_q;
    beat_d      = beat_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // Read-return stage: bus-cycle qualifiers delayed one cycle.
    rvalid_d    = gnt_q & {NREQ{in_burst & ~mem_we_q}};
    rbeat_d     = beat_q;
    if (!in_burst) begin
      if (|bus.req) begin
        gidx_d      = win;
        gnt_d       = '0;
        gnt_d[win]  = 1'b1;
        len_d       = len_v[win];
        mem_we_d    = bus.we[win];
        mem_addr_d  = addr_v[win];
        mem_wdata_d = wdata_v[win];
        beat_d      = 3'd0;
      end
    end else if (!last_beat) begin
      beat_d      = beat_q + 3'd1;
      mem_addr_d  = mem_addr_q + ADDR_W'(1);
      mem_wdata_d = wdata_v[gidx_q];
    end else begin
      gnt_d      = '0;
      mem_we_d   = 1'b0;
      beat_d     = 3'd0;
      last_gnt_d = gidx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q  <= 2'd2;
      gidx_q      <= 2'd0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      len_q       <= 3'd0;
      beat_q      <= 3'd0;
      rbeat_q     <= 3'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      gidx_q      <= gidx_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      rbeat_q     <= rbeat_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    bus.busy      = in_burst;
    bus.mem_en    = in_burst;
    bus.mem_we    = mem_we_q;
    bus.mem_addr  = mem_addr_q;
    bus.mem_wdata = mem_wdata_q;
    bus.gnt       = gnt_q;
    bus.beat_ack  = gnt_q & {NREQ{in_burst}};
    bus.rvalid    = rvalid_q;
    bus.rbeat     = rbeat_q;
    bus.rdata     = bus.mem_rdata;
  end
endmodule
